// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with an on-the-fly forward key schedule.
// Define AES_ENC_LAST_KEY_OUT_EN to export round key 10 on last_key for the decryptor.
module aes_enc_iter #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ptxt,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
`ifdef AES_ENC_LAST_KEY_OUT_EN
    output logic [127:0] last_key,
`endif
    output logic [127:0] ctxt
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] lo;
        lo = 11'd2040 - {b, 3'b000};
        return SBOX[lo +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte 4*c+r sits at bits [127-8*(4*c+r) -: 8].
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc_byte);
        logic [31:0] w0, w1, w2, w3, t;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc_byte, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, ctxt_q, ctxt_d;
    logic [3:0]   rc_q, rc_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic [127:0] sr, nk;

    assign sr = sub_shift(st_q);
    assign nk = next_key(rk_q, rcon(rc_q));

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rc_d    = rc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ctxt_d  = ctxt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    st_d    = ptxt ^ key;
                    rk_d    = key;
                    rc_d    = 4'd1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = StRound;
                end
            end
            StRound: begin
                rk_d = nk;
                st_d = mix_columns(sr) ^ nk;
                rc_d = rc_q + 4'd1;
                if (rc_q == 4'(NR - 1)) state_d = StFinal;
            end
            StFinal: begin
                ctxt_d  = sr ^ nk;
                rk_d    = nk;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                rc_d    = 4'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            st_q    <= '0;
            rk_q    <= '0;
            rc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctxt_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctxt_q  <= ctxt_d;
        end
    end

`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_key_q <= '0;
        end else if (state_q == StFinal) begin
            last_key_q <= nk;
        end
    end

    assign last_key = last_key_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign ctxt = ctxt_q;

endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Iterative AES-128 encryptor: one round per clock, on-the-fly forward key schedule, start/busy/done handshake.
- Counterpart of the team's iterative AES-128 decryptor. Ciphertext from this block, with the same key, must decrypt back to the plaintext.
- Sits beside the decryptor in the crypto datapath. Its final round key can be exported to seed the decryptor.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- start  input  1  request; sampled only in IDLE
- ptxt  input  128  plaintext; bits [127:120] = FIPS-197 byte 0, column-major
- key  input  128  cipher key, same byte order
- busy  output  1  high while rounds execute
- done  output  1  high while ctxt is valid; held until next accepted start
- ctxt  output  128  ciphertext, same byte order

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, busy=0, done=0, ctxt=0, rc=0.
  - Internal state and round-key registers are cleared to 0.
  - Reset mid-operation aborts the run immediately; no partial ctxt is ever exposed.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - On start==1, accept the request. Registers load st<=ptxt^key, rk<=key, rc<=1, busy<=1, done<=0.
  - Next state is ROUND.
  - ptxt and key need only be valid in the start cycle.
- ROUND (rc=1..9), each cycle:
  - rk<=next_key(rk,rcon[rc]).
  - st<=MixColumns(ShiftRows(SubBytes(st)))^next_key(rk,rcon[rc]).
  - rc<=rc+1.
  - When rc==9, next state is FINAL.
- FINAL (rc=10):
  - ctxt<=ShiftRows(SubBytes(st))^next_key(rk,rcon[10]).
  - rk<=that key, done<=1, busy<=0, rc<=0.
  - Next state is IDLE.
- Key schedule next_key(w0..w3,rcon):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- S-box: forward FIPS-197 table. Existing team S-box module or local function is acceptable; 20 S-box lookups combinational per round (16 state + 4 key).
- MixColumns: GF(2^8) with xtime reduction by 8'h1b.
- Latency: start accepted at edge N, done=1 and ctxt valid after edge N+10. Throughput: one block per 11 cycles (new start accepted in the cycle done is high).
- Handshake edges:
  - start while busy is ignored, no effect on the run.
  - start held high continuously re-triggers at every IDLE visit (done pulses for one cycle between runs).
  - done and ctxt persist in IDLE until the next accepted start, which clears done in the same edge it loads.
  - reset==0 and start==1 in the same cycle: reset wins.
- ctxt changes only on the FINAL edge and on reset.

Optional Feature:
- Macro: AES_ENC_LAST_KEY_OUT_EN.
- With the macro defined:
  - Extra output port last_key (output, 128) carries round key 10, registered on the FINAL edge with ctxt.
  - last_key resets to 0 and holds with done.
  - It feeds the decryptor's starting key directly.
- Without the macro: port absent, and no extra registers are inferred (rk is still used internally).

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ptxt=00112233445566778899aabbccddeeff, start 1 cycle -> done rises exactly 10 edges after the accept edge, ctxt=69c4e0d86a7b0430d8cdb78070b4c55a, busy high 10 cycles; with macro, last_key=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, ptxt=3243f6a8885a308d313198a2e0370734 -> ctxt=3925841d02dc09fbdc118597196a0b32; with macro, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- start pulsed again at rc=4 with different ptxt/key -> ignored; ctxt still matches the first vector and done is asserted only once.
- reset driven 0 for one cycle at rc=6 -> next edge busy=0, done=0, ctxt=0; a subsequent start with C.1 inputs -> correct C.1 ctxt 10 edges later.
- start held high across two back-to-back runs (C.1 then App.B inputs presented at the second accept) -> done high exactly one cycle between runs, second ctxt=3925841d..., accept interval 11 cycles.
- Loopback: random 50 key/ptxt pairs through this block, then the decryptor with the same key -> recovered plaintext equals original for all.
